// File: rtl/seq_signed_multiplier_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_signed_multiplier_if
// Description : Start/done handshake bundle for the iterative multiplier.
//               master : requester (drives start, tc, a, b; sees busy, done,
//                        product)
//               slave  : multiplier (the reverse)
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_signed_multiplier_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic               tc;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, tc, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, tc, a, b,
    output busy, done, product
  );
endinterface
`default_nettype wire

// File: rtl/seq_signed_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_signed_multiplier
// Description : Iterative shift-add WIDTH x WIDTH multiplier with a 2*WIDTH
//               result. Signed mode works on operand magnitudes and applies
//               the sign to the final product.
// Ports       : clk    - rising-edge clock
//               reset  - synchronous active-high reset
//               bus    - slave side of seq_signed_multiplier_if
//                        (start/tc/a/b in; busy/done/product out)
// Revision    : 1.0 - initial release
// ============================================================================
module seq_signed_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  seq_signed_multiplier_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH:0]     upper_sum;
  logic [CW-1:0]      count;
  logic               neg_flag;
  logic [2*WIDTH-1:0] product_r;
  logic               accept;
  logic               last;

  // New requests are only taken when nothing is in flight.
  assign accept = bus.start && ((state == IDLE) || (state == DONE));
  assign last   = (count == CW'(WIDTH - 1));

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = CALC;
      CALC:    if (last)      state_next = DONE;
      DONE:    state_next = bus.start ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // One shift-add step. The upper-half sum keeps its carry so the shifted
  // accumulator never loses the top bit.
  // --------------------------------------------------------------------------
  always_comb begin
    upper_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
    acc_step  = (2*WIDTH)'({upper_sum, acc[WIDTH-1:0]} >> 1);
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      count     <= '0;
      neg_flag  <= 1'b0;
      product_r <= '0;
    end else if (accept) begin
      // Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which fits unsigned.
      mcand    <= (bus.tc && bus.a[WIDTH-1]) ? ('0 - bus.a) : bus.a;
      mplier   <= (bus.tc && bus.b[WIDTH-1]) ? ('0 - bus.b) : bus.b;
      neg_flag <= bus.tc && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      acc      <= '0;
      count    <= '0;
    end else if (state == CALC) begin
      acc    <= acc_step;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
      // Negating a zero magnitude yields zero, so no negative zero appears.
      if (last) begin
        product_r <= neg_flag ? ('0 - acc_step) : acc_step;
      end
    end
  end

  assign bus.busy    = (state == CALC);
  assign bus.done    = (state == DONE);
  assign bus.product = product_r;

endmodule
`default_nettype wire

// File: tb/tb_seq_signed_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_signed_multiplier
// Description : Self-checking bench for seq_signed_multiplier (WIDTH=8).
//               A cycle-level reference model predicts busy/done/product from
//               arithmetic products; directed vectors pin literal results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_signed_multiplier;

  localparam int W = 8;

  logic clk;
  logic reset;

  seq_signed_multiplier_if #(.WIDTH(W)) bus ();

  seq_signed_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // --------------------------------------------------------------------------
  // Reference model: plain arithmetic product plus a remaining-cycle counter.
  // --------------------------------------------------------------------------
  function automatic logic [2*W-1:0] ref_mul(input logic t, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
    longint p;
    if (t) p = longint'($signed(x)) * longint'($signed(y));
    else   p = longint'(x) * longint'(y);
    return p[2*W-1:0];
  endfunction

  int             m_rem;
  logic           m_done;
  logic [2*W-1:0] m_prod;
  logic [2*W-1:0] m_pend;

  always @(posedge clk) begin
    if (reset) begin
      m_rem  <= 0;
      m_done <= 1'b0;
      m_prod <= '0;
      m_pend <= '0;
    end else if (m_rem > 0) begin
      m_rem  <= m_rem - 1;
      m_done <= (m_rem == 1);
      if (m_rem == 1) m_prod <= m_pend;
    end else begin
      m_done <= 1'b0;
      if (bus.start) begin
        m_rem  <= W;
        m_pend <= ref_mul(bus.tc, bus.a, bus.b);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",    64'(bus.busy),    64'(m_rem > 0));
      check("done",    64'(bus.done),    64'(m_done));
      check("product", 64'(bus.product), 64'(m_prod));
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  task automatic run_op(input logic t, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [2*W-1:0] exp, input string nm);
    int lat;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    bus.start = 1'b1; bus.tc = t; bus.a = x; bus.b = y;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1; busy_cnt = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      if (bus.done) seen = 1'b1;
      else begin
        if (bus.busy) busy_cnt++;
        @(negedge clk);
        lat++;
      end
    end
    check({nm, " latency"}, 64'(lat), 64'(W + 1));
    check({nm, " busy cycles"}, 64'(busy_cnt), 64'(W));
    check({nm, " result"}, 64'(bus.product), 64'(exp));
  endtask

  initial begin
    int dones;
    bus.start = 1'b0; bus.tc = 1'b0; bus.a = '0; bus.b = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    check("reset busy",    64'(bus.busy),    64'd0);
    check("reset done",    64'(bus.done),    64'd0);
    check("reset product", 64'(bus.product), 64'd0);

    run_op(1'b1, 8'd5,   8'd13,  16'h0041, "s 5x13");
    run_op(1'b1, 8'd5,   8'hF3,  16'hFFBF, "s 5x-13");
    run_op(1'b1, 8'hFB,  8'hF3,  16'h0041, "s -5x-13");
    run_op(1'b1, 8'h80,  8'h80,  16'h4000, "s min x min");
    run_op(1'b1, 8'h80,  8'h7F,  16'hC080, "s min x max");
    run_op(1'b1, 8'hFF,  8'hFF,  16'h0001, "s -1x-1");
    run_op(1'b0, 8'hFF,  8'hFF,  16'hFE01, "u ffxff");
    run_op(1'b0, 8'h80,  8'h02,  16'h0100, "u 80x02");
    run_op(1'b0, 8'h00,  8'hAB,  16'h0000, "u 0xab");
    run_op(1'b1, 8'h00,  8'hF3,  16'h0000, "s 0x-13");

    // start held high: back-to-back operations, a changed mid-CALC
    @(negedge clk);
    bus.start = 1'b1; bus.tc = 1'b0; bus.a = 8'd3; bus.b = 8'd4;
    dones = 0;
    for (int i = 1; i <= 27; i++) begin
      @(negedge clk);
      if (i == 4) bus.a = 8'd7;
      if (bus.done) begin
        dones++;
        if (i == 9) check("held first", 64'(bus.product), 64'h000C);
        else        check("held next",  64'(bus.product), 64'h001C);
        check("held done spacing", 64'(i % 9), 64'd0);
      end
    end
    check("held done count", 64'(dones), 64'd3);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);

    // start pulse during CALC is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.tc = 1'b1; bus.a = 8'd5; bus.b = 8'd13;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'd9; bus.b = 8'd9;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        dones++;
        check("ignored start result", 64'(bus.product), 64'h0041);
      end
    end
    check("ignored start done count", 64'(dones), 64'd1);
    check("ignored start idle", 64'(bus.busy), 64'd0);

    // reset during CALC
    @(negedge clk);
    bus.start = 1'b1; bus.tc = 1'b0; bus.a = 8'd2; bus.b = 8'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid reset busy",    64'(bus.busy),    64'd0);
    check("mid reset done",    64'(bus.done),    64'd0);
    check("mid reset product", 64'(bus.product), 64'd0);
    run_op(1'b1, 8'd2, 8'd3, 16'h0006, "after reset 2x3");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
